fetch_exec_sequencer: RTL and testbench

//  Sequences the TSC datapath into a FETCH/EXEC cycle over a handshaked memory port: owns PC,

---
 rtl/fetch_exec_sequencer_pkg.sv | 19 +
 rtl/fetch_exec_sequencer_timeout.sv | 36 +++
 rtl/fetch_exec_sequencer.sv | 129 ++++++++++++
 tb/tb_fetch_exec_sequencer.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_exec_sequencer_pkg.sv
// Shared constants for the fetch/exec sequencer: state encodings and the watchdog
// counter sizing helper.
package fetch_exec_sequencer_pkg;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] SEQ_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] SEQ_FETCH = 2'd1;
  localparam logic [STATE_W-1:0] SEQ_EXEC  = 2'd2;
  localparam logic [STATE_W-1:0] SEQ_HALT  = 2'd3;

  // Low PC bits replaced by a jump target; upper bits keep the current page.
  localparam int JUMP_LO_W = 12;

  function automatic int cnt_width(input int unsigned limit);
    return (limit < 32'd2) ? 1 : $clog2(limit + 32'd1);
  endfunction

endpackage

// File: rtl/fetch_exec_sequencer_timeout.sv
// fetch_timeout_counter: counts consecutive FETCH cycles without mem_ready and flags
// the cycle in which the wait limit is reached. Cleared whenever FETCH is not active.
module fetch_timeout_counter
  import fetch_exec_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_active,
  input  logic i_ready,
  output logic o_expired
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Wait-cycle counter; saturates at the limit so it never wraps back to zero.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_count <= {CNT_W{1'b0}};
    end else if (!i_active) begin
      r_count <= {CNT_W{1'b0}};
    end else if (r_count != LIMIT) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  // A ready response in the limit cycle wins over the timeout.
  assign o_expired = i_active & ~i_ready & (r_count == LIMIT);

endmodule

// File: rtl/fetch_exec_sequencer.sv
// fetch_exec_sequencer: FETCH/EXEC sequencer owning PC, instruction register and the
// retired count. Define FETCH_TIMEOUT_EN to enable the FETCH watchdog and fetch_err.
module fetch_exec_sequencer
  import fetch_exec_sequencer_pkg::*;
#(
  parameter int                WORD_W         = 16,
  parameter int                ADDR_W         = 16,
  parameter logic [ADDR_W-1:0] RESET_PC       = {ADDR_W{1'b0}},
  parameter int                TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [WORD_W-1:0] mem_data,
  output logic [WORD_W-1:0] instr,
  input  logic              jump_in,
  input  logic              regwrite_in,
  input  logic              is_wwd_in,
  input  logic              is_halt_in,
  output logic [ADDR_W-1:0] pc,
  output logic              reg_write_en,
  output logic              wwd_strobe,
  output logic [15:0]       num_inst,
  output logic              halted,
  output logic              fetch_err
);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_next;
  logic [WORD_W-1:0]  r_instr;
  logic [15:0]        r_num_inst;
  logic               r_mem_read;
  logic               r_halted;
  logic               w_in_fetch;
  logic               w_in_exec;
  logic               w_timeout;

  assign w_in_fetch = (r_state == SEQ_FETCH);
  assign w_in_exec  = (r_state == SEQ_EXEC);

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fetch_timeout (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_active (w_in_fetch),
    .i_ready  (mem_ready),
    .o_expired(w_timeout)
  );
`else
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SEQ_IDLE: w_next_state = SEQ_FETCH;
      SEQ_FETCH: begin
        if (mem_ready) begin
          w_next_state = SEQ_EXEC;
        end else if (w_timeout) begin
          w_next_state = SEQ_IDLE;
        end else begin
          w_next_state = SEQ_FETCH;
        end
      end
      SEQ_EXEC: begin
        if (is_halt_in) begin
          w_next_state = SEQ_HALT;
        end else begin
          w_next_state = SEQ_FETCH;
        end
      end
      SEQ_HALT: w_next_state = SEQ_HALT;
      default:  w_next_state = SEQ_IDLE;
    endcase
  end

  // PC successor: page-relative jump or sequential increment with natural wrap.
  always_comb begin
    if (jump_in) begin
      w_pc_next = {r_pc[ADDR_W-1:JUMP_LO_W], r_instr[JUMP_LO_W-1:0]};
    end else begin
      w_pc_next = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  // Sequencer state; mem_read and halted are registered from the next state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state    <= SEQ_IDLE;
      r_pc       <= RESET_PC;
      r_instr    <= {WORD_W{1'b0}};
      r_num_inst <= 16'd0;
      r_mem_read <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_mem_read <= (w_next_state == SEQ_FETCH);
      r_halted   <= (w_next_state == SEQ_HALT);
      if (w_in_fetch && mem_ready) begin
        r_instr <= mem_data;
      end
      if (w_in_exec) begin
        r_num_inst <= r_num_inst + 16'd1;
        if (!is_halt_in) begin
          r_pc <= w_pc_next;
        end
      end
    end
  end

  assign mem_read     = r_mem_read;
  assign mem_addr     = r_pc;
  assign pc           = r_pc;
  assign instr        = r_instr;
  assign num_inst     = r_num_inst;
  assign halted       = r_halted;
  assign reg_write_en = w_in_exec & regwrite_in & ~is_halt_in;
  assign wwd_strobe   = w_in_exec & is_wwd_in & ~is_halt_in;
  assign fetch_err    = w_timeout;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Self-checking bench for fetch_exec_sequencer: bench-side memory and decoder, a model
// pushing expected EXEC results to a scoreboard queue, one task per scenario.
`timescale 1ns/1ps
module tb_fetch_exec_sequencer;

  localparam logic [15:0] I_NOP = 16'hB000;
  localparam logic [15:0] I_ADD = 16'hF000;
  localparam logic [15:0] I_WWD = 16'hF01C;
  localparam logic [15:0] I_HLT = 16'hF01D;

  logic        clk = 1'b0;
  logic        reset_n, mem_read, mem_ready;
  logic [15:0] mem_addr, mem_data, instr, pc, num_inst;
  logic        jump_in, regwrite_in, is_wwd_in, is_halt_in;
  logic        reg_write_en, wwd_strobe, halted, fetch_err;

  always #5 clk = ~clk;

  fetch_exec_sequencer dut (
    .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_data(mem_data), .instr(instr), .jump_in(jump_in),
    .regwrite_in(regwrite_in), .is_wwd_in(is_wwd_in), .is_halt_in(is_halt_in), .pc(pc),
    .reg_write_en(reg_write_en), .wwd_strobe(wwd_strobe), .num_inst(num_inst),
    .halted(halted), .fetch_err(fetch_err)
  );

  // Control-unit stand-in decoding the instruction register.
  assign jump_in     = (instr[15:12] == 4'h9);
  assign regwrite_in = (instr[15:12] == 4'hF) && (instr[5:0] == 6'd0);
  assign is_wwd_in   = (instr[15:12] == 4'hF) && (instr[5:0] == 6'd28);
  assign is_halt_in  = (instr[15:12] == 4'hF) && (instr[5:0] == 6'd29);

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc_next;
    logic [15:0] num;
    logic        rw;
    logic        wwd;
    logic        halt;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem [logic [15:0]];
  logic [15:0] m_pc, m_num;
  int          errors = 0;
  int          checks = 0;

  int          obs_rd_cycles, obs_early, obs_moved, obs_ferr, obs_addr_bad;
  logic [15:0] obs_exec_instr, obs_pc, obs_num, obs_post_instr;
  logic        obs_exec_rw, obs_exec_wwd, obs_exec_mr, obs_halted;
  logic        obs_post_rw, obs_post_wwd, obs_post_mr;

  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : I_NOP;
  endfunction

  // Drives one FETCH (after lat wait cycles) and the following EXEC, recording observations.
  task automatic feed(input int lat);
    logic [15:0] d, ir0;
    exp_t        e;
    int          guard = 0;
    obs_rd_cycles = 0; obs_early = 0; obs_moved = 0; obs_ferr = 0; obs_addr_bad = 0;
    while (mem_read !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL feed_wait_fetch: mem_read=%b required 1", mem_read);
    end
    ir0 = instr;
    for (int i = 0; i <= lat; i++) begin
      if (mem_read === 1'b1) obs_rd_cycles++;
      if (reg_write_en !== 1'b0 || wwd_strobe !== 1'b0) obs_early++;
      if (mem_addr !== m_pc) obs_addr_bad++;
      if (fetch_err !== 1'b0) obs_ferr++;
      if (i < lat) begin
        mem_ready = 1'b0;
        mem_data  = 16'($urandom);
        @(negedge clk);
        if (instr !== ir0) obs_moved++;
      end
    end
    d = rd(m_pc);
    e.instr = d;
    e.rw    = (d[15:12] == 4'hF) && (d[5:0] == 6'd0);
    e.wwd   = (d[15:12] == 4'hF) && (d[5:0] == 6'd28);
    e.halt  = (d[15:12] == 4'hF) && (d[5:0] == 6'd29);
    e.num   = m_num + 16'd1;
    if (e.halt)                  e.pc_next = m_pc;
    else if (d[15:12] == 4'h9)   e.pc_next = {m_pc[15:12], d[11:0]};
    else                         e.pc_next = m_pc + 16'd1;
    exp_q.push_back(e);
    mem_ready = 1'b1;
    mem_data  = d;
    @(negedge clk);
    obs_exec_instr = instr; obs_exec_rw = reg_write_en; obs_exec_wwd = wwd_strobe;
    obs_exec_mr = mem_read;
    mem_data = ~d;
    @(negedge clk);
    obs_pc = pc; obs_num = num_inst; obs_halted = halted; obs_post_instr = instr;
    obs_post_rw = reg_write_en; obs_post_wwd = wwd_strobe; obs_post_mr = mem_read;
    mem_ready = 1'b0;
    m_pc  = e.pc_next;
    m_num = e.num;
  endtask

  task automatic test_reset;
    reset_n = 1'b1; mem_ready = 1'b1; mem_data = 16'h1234;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_read, reg_write_en, wwd_strobe, halted, fetch_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 00000",
               {mem_read, reg_write_en, wwd_strobe, halted, fetch_err});
    end
    checks++;
    if (pc !== 16'h0 || instr !== 16'h0 || num_inst !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs: pc=%h instr=%h num=%h required 0", pc, instr, num_inst);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== 16'h0 || instr !== 16'h0) begin
      errors++;
      $display("FAIL first_fetch: mem_read=%b addr=%h instr=%h required 1/0000/0000",
               mem_read, mem_addr, instr);
    end
    m_pc = 16'h0; m_num = 16'h0; exp_q.delete();
  endtask

  task automatic test_basic;
    exp_t e;
    feed(0);
    e = exp_q.pop_front();
    checks++;
    if (obs_pc !== 16'h0001 || obs_num !== 16'd1) begin
      errors++;
      $display("FAIL basic_pc_count: pc=%h num=%0d required 0001/1", obs_pc, obs_num);
    end
    checks++;
    if (obs_exec_instr !== e.instr || obs_rd_cycles !== 1) begin
      errors++;
      $display("FAIL basic_fetch: instr=%h rd_cycles=%0d required %h/1",
               obs_exec_instr, obs_rd_cycles, e.instr);
    end
  endtask

  task automatic test_strobes;
    exp_t e;
    mem[16'h0001] = I_ADD;
    mem[16'h0002] = I_WWD;
    feed(0);
    e = exp_q.pop_front();
    checks++;
    if ({obs_exec_rw, obs_exec_wwd, obs_exec_mr} !== 3'b100) begin
      errors++;
      $display("FAIL add_strobe: rw/wwd/rd=%b required 100",
               {obs_exec_rw, obs_exec_wwd, obs_exec_mr});
    end
    checks++;
    if ({obs_post_rw, obs_post_wwd} !== 2'b00) begin
      errors++;
      $display("FAIL add_strobe_len: post rw/wwd=%b required 00", {obs_post_rw, obs_post_wwd});
    end
    feed(0);
    e = exp_q.pop_front();
    checks++;
    if ({obs_exec_rw, obs_exec_wwd} !== 2'b01 || {obs_post_rw, obs_post_wwd} !== 2'b00) begin
      errors++;
      $display("FAIL wwd_strobe: exec=%b post=%b required 01/00",
               {obs_exec_rw, obs_exec_wwd}, {obs_post_rw, obs_post_wwd});
    end
    checks++;
    if (obs_pc !== e.pc_next || obs_num !== e.num) begin
      errors++;
      $display("FAIL wwd_pc: pc=%h num=%0d required %h/%0d", obs_pc, obs_num, e.pc_next, e.num);
    end
  endtask

  task automatic test_delay;
    exp_t e;
    mem[16'h0003] = I_ADD;
    feed(5);
    e = exp_q.pop_front();
    checks++;
    if (obs_rd_cycles !== 6) begin
      errors++;
      $display("FAIL delay_read_len: mem_read cycles=%0d required 6", obs_rd_cycles);
    end
    checks++;
    if (obs_early !== 0 || obs_moved !== 0 || obs_addr_bad !== 0 || obs_ferr !== 0) begin
      errors++;
      $display("FAIL delay_wait: early=%0d moved=%0d addr_bad=%0d ferr=%0d required 0",
               obs_early, obs_moved, obs_addr_bad, obs_ferr);
    end
    checks++;
    if (obs_exec_instr !== e.instr || obs_exec_rw !== 1'b1 || obs_post_instr !== e.instr) begin
      errors++;
      $display("FAIL delay_latch: exec=%h rw=%b post=%h required %h/1/%h",
               obs_exec_instr, obs_exec_rw, obs_post_instr, e.instr, e.instr);
    end
  endtask

  task automatic test_jump;
    exp_t        e;
    logic [15:0] pc_before;
    logic        wrapped = 1'b0;
    logic        hit = 1'b0;
    mem[16'h0004] = 16'h9FFF;
    mem[16'h3000] = 16'h9005;
    mem[16'h3005] = 16'h9123;
    mem[16'h3123] = 16'h9FFF;
    for (int n = 1; n < 16; n++) begin
      if (n != 3) mem[{4'(n), 12'h000}] = 16'h9FFF;
    end
    for (int i = 0; i < 48 && !wrapped; i++) begin
      pc_before = m_pc;
      feed(i % 2);
      e = exp_q.pop_front();
      checks++;
      if (obs_pc !== e.pc_next || obs_num !== e.num || obs_addr_bad !== 0) begin
        errors++;
        $display("FAIL jump_walk: from %h pc=%h num=%0d addr_bad=%0d required %h/%0d/0",
                 pc_before, obs_pc, obs_num, obs_addr_bad, e.pc_next, e.num);
      end
      if (pc_before == 16'h3005) begin
        hit = 1'b1;
        checks++;
        if (obs_pc !== 16'h3123) begin
          errors++;
          $display("FAIL jump_page: pc=%h required 3123", obs_pc);
        end
      end
      if (pc_before == 16'hFFFF) begin
        wrapped = 1'b1;
        checks++;
        if (obs_pc !== 16'h0000) begin
          errors++;
          $display("FAIL pc_wrap: pc=%h required 0000", obs_pc);
        end
      end
    end
    checks++;
    if ({hit, wrapped} !== 2'b11) begin
      errors++;
      $display("FAIL jump_walk_reach: hit3005/wrapped=%b required 11", {hit, wrapped});
    end
  endtask

  task automatic test_halt;
    exp_t        e;
    logic [15:0] n0;
    int          viol = 0;
    mem[m_pc] = I_HLT;
    n0 = m_num;
    feed(0);
    e = exp_q.pop_front();
    checks++;
    if ({obs_exec_rw, obs_exec_wwd} !== 2'b00 || obs_halted !== 1'b1 || obs_post_mr !== 1'b0) begin
      errors++;
      $display("FAIL halt_entry: strobes=%b halted=%b mem_read=%b required 00/1/0",
               {obs_exec_rw, obs_exec_wwd}, obs_halted, obs_post_mr);
    end
    checks++;
    if (obs_pc !== e.pc_next || obs_num !== (n0 + 16'd1)) begin
      errors++;
      $display("FAIL halt_pc_count: pc=%h num=%0d required %h/%0d",
               obs_pc, obs_num, e.pc_next, n0 + 16'd1);
    end
    mem_ready = 1'b1;
    mem_data  = I_ADD;
    repeat (20) begin
      @(negedge clk);
      if (mem_read !== 1'b0 || reg_write_en !== 1'b0 || wwd_strobe !== 1'b0 ||
          halted !== 1'b1 || pc !== e.pc_next || num_inst !== (n0 + 16'd1)) viol++;
    end
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL halt_sticky: violating cycles=%0d required 0", viol);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    reset_n = 1'b1;
    @(negedge clk);
    reset_n = 1'b0; m_pc = 16'h0; m_num = 16'h0; exp_q.delete();
    mem[16'h0000] = I_ADD;
    @(negedge clk);
    feed(0);
    e = exp_q.pop_front();
    repeat (2) @(negedge clk);
    reset_n = 1'b1; mem_ready = 1'b1; mem_data = I_WWD;
    @(negedge clk);
    checks++;
    if (pc !== 16'h0 || num_inst !== 16'h0 || instr !== 16'h0 ||
        {mem_read, reg_write_en, wwd_strobe} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_fetch: pc=%h num=%0d instr=%h flags=%b required 0",
               pc, num_inst, instr, {mem_read, reg_write_en, wwd_strobe});
    end
    reset_n = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1; mem_data = I_ADD;
    @(negedge clk);
    checks++;
    if (reg_write_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_exec_pre: reg_write_en=%b required 1", reg_write_en);
    end
    reset_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (pc !== 16'h0 || num_inst !== 16'h0 || reg_write_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_exec: pc=%h num=%0d rw=%b required 0/0/0",
               pc, num_inst, reg_write_en);
    end
    reset_n = 1'b0; m_pc = 16'h0; m_num = 16'h0;
    @(negedge clk);
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout;
    exp_t e;
    int   hit_at = 0;
    mem_ready = 1'b0;
    for (int i = 1; i <= 40 && hit_at == 0; i++) begin
      if (fetch_err === 1'b1) hit_at = i;
      else @(negedge clk);
    end
    checks++;
    if (hit_at !== 15) begin
      errors++;
      $display("FAIL timeout_cycle: fetch_err at FETCH cycle %0d required 15", hit_at);
    end
    @(negedge clk);
    checks++;
    if ({mem_read, fetch_err} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_idle: mem_read/fetch_err=%b required 00", {mem_read, fetch_err});
    end
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1 || mem_addr !== m_pc || num_inst !== m_num) begin
      errors++;
      $display("FAIL timeout_refetch: rd=%b addr=%h num=%0d required 1/%h/%0d",
               mem_read, mem_addr, num_inst, m_pc, m_num);
    end
    feed(0);
    e = exp_q.pop_front();
    checks++;
    if (obs_pc !== e.pc_next || obs_num !== e.num) begin
      errors++;
      $display("FAIL timeout_resume: pc=%h num=%0d required %h/%0d",
               obs_pc, obs_num, e.pc_next, e.num);
    end
  endtask
`endif

  initial begin
    reset_n = 1'b1; mem_ready = 1'b0; mem_data = 16'h0;
    m_pc = 16'h0; m_num = 16'h0;
    test_reset;
    test_basic;
    test_strobes;
    test_delay;
    test_jump;
    test_halt;
    test_reset_mid;
`ifdef FETCH_TIMEOUT_EN
    test_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
